hazard_issue: RTL and testbench
===============================

HAZARD_ISSUE -- requirements
Module: hazard_issue

Interface
REQ-001 Parameter DEPTH, default 4: number of issued instructions tracked (decode, execute, memory, write-back slots).
REQ-002 Parameter NOP, default 32'h0000_0000: word driven into the pipeline on a bubble.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_inst  input  32  fetched instruction from instruction memory.
REQ-006 in_valid  input  1  in_inst is valid this cycle.
REQ-007 in_ready  output  1  combinational; high = slot accepts in_inst this cycle, also used as PC enable.
REQ-008 out_inst  output  32  registered instruction to the control/decode stage.
REQ-009 out_valid  output  1  registered; out_inst is a real instruction, not a bubble.
REQ-010 stall_cnt  output  16  saturating count of bubble cycles caused by hazards.
REQ-011 issue_cnt  output  16  wrapping count of issued instructions.

Function
REQ-012 Instruction fields: rd=[31:27], rs=[26:22], rt=[21:17], imm_sel=[14], store=[12], reg_write=[10].
REQ-013 Source use: rs always read; rt read when imm_sel==0 or store==1.
REQ-014 One candidate register (cur_inst, cur_valid) holds the instruction under hazard check.
REQ-015 Scoreboard: DEPTH entries {wr, rd}; every cycle entry k <= entry k-1, entry 0 <= issued instruction's {reg_write, rd}, or {0,0} on bubble; oldest entry drops.
REQ-016 hazard = cur_valid and some used source equals rd of any entry with wr==1; register 0 is compared like any other.
REQ-017 Issue: cur_valid and not hazard -> out_inst<=cur_inst, out_valid<=1, issue_cnt+1, slot freed same edge.
REQ-018 Bubble: otherwise -> out_inst<=NOP, out_valid<=0; stall_cnt+1 (saturate at 16'hFFFF) only when hazard==1.
REQ-019 in_ready = not cur_valid or not hazard.
REQ-020 in_valid and in_ready -> cur_inst<=in_inst, cur_valid<=1; issue and refill in the same cycle is allowed (full throughput: 1 instruction/clock with no hazards).
REQ-021 in_ready and not in_valid and slot freed -> cur_valid<=0.
REQ-022 Latency: instruction accepted at edge N appears on out_inst at edge N+1 with no hazard; each hazard cycle adds one.
REQ-023 A stalled instruction remains in cur unchanged; in_inst is ignored while in_ready==0.
REQ-024 Maximum stall for one dependence = DEPTH cycles; hazard clears once the producer leaves entry DEPTH-1.
REQ-025 issue_cnt wraps 16'hFFFF -> 16'h0000.

Reset
REQ-026 rst high -> immediately: cur_valid=0, out_inst=NOP, out_valid=0, all scoreboard entries {0,0}, stall_cnt=0, issue_cnt=0.
REQ-027 in_ready=1 while rst high and in the first cycle after release.
REQ-028 Reset mid-stall discards cur and scoreboard; no instruction issued after release until new in_valid.

Verification
REQ-029 Independent stream of 8 instructions, reg_write=1, distinct rd/rs -> 8 consecutive out_valid=1, stall_cnt=0, issue_cnt=8.
REQ-030 I1 writes r3, I2 reads rs=r3 back-to-back -> 4 bubble cycles (out_inst=NOP), I2 issued 5 edges after I1, stall_cnt=4, in_ready low for those 4 cycles.
REQ-031 Producer then 2 independent instructions then consumer of r3 -> consumer stalls exactly 2 cycles.
REQ-032 I1 writes r5; I2 has imm_sel=1, store=0, rt=r5 -> no stall (rt unused); same I2 with store=1 -> stall 4.
REQ-033 Force stall_cnt to 16'hFFFE, two more hazard cycles -> stall_cnt 16'hFFFF, holds; issue_cnt 16'hFFFF plus one issue -> 16'h0000.
REQ-034 Assert rst asynchronously during a stall -> outputs at reset values before next edge; released, first new instruction issues with no stall.

Source files
------------

// File: rtl/hazard_issue.sv
// Hazard-checking issue stage: holds one fetched instruction and inserts bubbles
// while any of its source registers is pending in the in-flight writer scoreboard.
module hazard_issue #(
  parameter int unsigned DEPTH = 4,
  parameter logic [31:0] NOP   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_inst,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_inst,
  output logic        out_valid,
  output logic [15:0] stall_cnt,
  output logic [15:0] issue_cnt
);

  logic [31:0]            cur_inst_q, cur_inst_d;
  logic                   cur_valid_q, cur_valid_d;
  logic [31:0]            out_inst_q, out_inst_d;
  logic                   out_valid_q, out_valid_d;
  logic [15:0]            stall_cnt_q, stall_cnt_d;
  logic [15:0]            issue_cnt_q, issue_cnt_d;
  logic [DEPTH-1:0]       sb_wr_q, sb_wr_d;
  logic [DEPTH-1:0][4:0]  sb_rd_q, sb_rd_d;

  logic [4:0] rs, rt;
  logic       rt_used;
  logic       hazard;
  logic       issue;

  assign rs      = cur_inst_q[26:22];
  assign rt      = cur_inst_q[21:17];
  assign rt_used = !cur_inst_q[14] || cur_inst_q[12];

  // Register 0 is deliberately treated like any other register.
  always_comb begin
    hazard = 1'b0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (sb_wr_q[k] && ((sb_rd_q[k] == rs) || (rt_used && (sb_rd_q[k] == rt)))) begin
        hazard = 1'b1;
      end
    end
    hazard = hazard && cur_valid_q;
  end

  assign issue    = cur_valid_q && !hazard;
  assign in_ready = !cur_valid_q || !hazard;

  always_comb begin
    cur_inst_d  = cur_inst_q;
    cur_valid_d = cur_valid_q;
    out_inst_d  = NOP;
    out_valid_d = 1'b0;
    stall_cnt_d = stall_cnt_q;
    issue_cnt_d = issue_cnt_q;
    sb_wr_d     = '0;
    sb_rd_d     = '0;

    if (issue) begin
      out_inst_d  = cur_inst_q;
      out_valid_d = 1'b1;
      issue_cnt_d = issue_cnt_q + 16'd1;
      sb_wr_d[0]  = cur_inst_q[10];
      sb_rd_d[0]  = cur_inst_q[31:27];
    end else if (hazard && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end

    for (int unsigned k = 1; k < DEPTH; k++) begin
      sb_wr_d[k] = sb_wr_q[k-1];
      sb_rd_d[k] = sb_rd_q[k-1];
    end

    // A ready slot is either empty or being freed by this issue.
    if (in_ready) begin
      cur_valid_d = in_valid;
      if (in_valid) begin
        cur_inst_d = in_inst;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_inst_q  <= NOP;
      cur_valid_q <= 1'b0;
      out_inst_q  <= NOP;
      out_valid_q <= 1'b0;
      stall_cnt_q <= '0;
      issue_cnt_q <= '0;
      sb_wr_q     <= '0;
      sb_rd_q     <= '0;
    end else begin
      cur_inst_q  <= cur_inst_d;
      cur_valid_q <= cur_valid_d;
      out_inst_q  <= out_inst_d;
      out_valid_q <= out_valid_d;
      stall_cnt_q <= stall_cnt_d;
      issue_cnt_q <= issue_cnt_d;
      sb_wr_q     <= sb_wr_d;
      sb_rd_q     <= sb_rd_d;
    end
  end

  assign out_inst  = out_inst_q;
  assign out_valid = out_valid_q;
  assign stall_cnt = stall_cnt_q;
  assign issue_cnt = issue_cnt_q;

endmodule

// File: tb/tb_hazard_issue.sv
// Self-checking bench for hazard_issue: directed scenarios plus random traffic,
// compared against a register-age reference model.
module tb_hazard_issue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_inst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_inst;
  logic        out_valid;
  logic [15:0] stall_cnt;
  logic [15:0] issue_cnt;

  hazard_issue #(.DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_inst   (in_inst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_inst  (out_inst),
    .out_valid (out_valid),
    .stall_cnt (stall_cnt),
    .issue_cnt (issue_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: each register remembers the edge at which its latest writer issued.
  int          edge_n;
  int          last_wr [32];
  logic [31:0] m_cur;
  logic        m_cur_v;
  logic [31:0] m_out;
  logic        m_out_v;
  logic [15:0] m_stall;
  logic [15:0] m_issue;
  int          ov_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int rd, input int rs, input int rt,
                                     input bit imm, input bit st, input bit rw);
    logic [31:0] w;
    w        = '0;
    w[31:27] = rd[4:0];
    w[26:22] = rs[4:0];
    w[21:17] = rt[4:0];
    w[14]    = imm;
    w[12]    = st;
    w[10]    = rw;
    return w;
  endfunction

  function automatic bit busy(input logic [4:0] r);
    return (edge_n - last_wr[r]) < DEPTH;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) last_wr[i] = -1000;
    m_cur_v = 1'b0;
    m_cur   = NOP;
    m_out   = NOP;
    m_out_v = 1'b0;
    m_stall = '0;
    m_issue = '0;
  endtask

  // One clock: drive inputs, check in_ready, advance model, check registered outputs.
  task automatic cycle(input logic [31:0] inst, input logic v);
    bit hz, rdy, iss;
    in_inst  = inst;
    in_valid = v;
    #1;
    hz  = m_cur_v && (busy(m_cur[26:22]) ||
          ((!m_cur[14] || m_cur[12]) && busy(m_cur[21:17])));
    rdy = !m_cur_v || !hz;
    chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
    @(posedge clk);
    edge_n++;
    iss = m_cur_v && !hz;
    if (iss) begin
      m_out   = m_cur;
      m_out_v = 1'b1;
      m_issue = m_issue + 16'd1;
      if (m_cur[10]) last_wr[m_cur[31:27]] = edge_n;
    end else begin
      m_out   = NOP;
      m_out_v = 1'b0;
      if (hz && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
    end
    if (rdy) begin
      m_cur_v = v;
      if (v) m_cur = inst;
    end
    #1;
    chk("out_inst", out_inst, m_out);
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_out_v});
    chk("stall_cnt", {16'd0, stall_cnt}, {16'd0, m_stall});
    chk("issue_cnt", {16'd0, issue_cnt}, {16'd0, m_issue});
    if (out_valid) ov_seen++;
  endtask

  // Feed an instruction until accepted, bounded so a stuck in_ready cannot hang the run.
  task automatic push(input logic [31:0] inst);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3 * DEPTH + 4 && !done; i++) begin
      done = !m_cur_v || !(busy(m_cur[26:22]) ||
             ((!m_cur[14] || m_cur[12]) && busy(m_cur[21:17])));
      cycle(inst, 1'b1);
    end
    chk("push_accepted", {31'd0, done}, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 3; i++) cycle(NOP, 1'b0);
  endtask

  logic [15:0] s0;
  int          o0;
  logic [31:0] w;

  initial begin
    rst      = 1'b1;
    in_inst  = '0;
    in_valid = 1'b0;
    edge_n   = 0;
    ov_seen  = 0;
    model_reset();
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_inst", out_inst, NOP);
    chk("rst_stall", {16'd0, stall_cnt}, 32'd0);
    chk("rst_issue", {16'd0, issue_cnt}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Independent stream at full throughput.
    o0 = ov_seen;
    for (int i = 0; i < 8; i++) cycle(mk(8 + i, 20 + i, 20 + i, 1'b0, 1'b0, 1'b1), 1'b1);
    cycle(NOP, 1'b0);
    chk("indep_out_valid_count", ov_seen - o0, 32'd8);
    chk("indep_stall", {16'd0, stall_cnt}, 32'd0);
    chk("indep_issue", {16'd0, issue_cnt}, 32'd8);
    drain();

    // Back-to-back RAW on r3: four bubbles.
    s0 = stall_cnt;
    push(mk(3, 1, 2, 1'b0, 1'b0, 1'b1));
    push(mk(7, 3, 9, 1'b1, 1'b0, 1'b1));
    drain();
    chk("raw_b2b_stalls", {16'd0, stall_cnt - s0}, 32'd4);

    // Two independent instructions in between: two bubbles.
    s0 = stall_cnt;
    push(mk(3, 1, 2, 1'b0, 1'b0, 1'b1));
    push(mk(10, 11, 12, 1'b0, 1'b0, 1'b1));
    push(mk(13, 14, 15, 1'b0, 1'b0, 1'b1));
    push(mk(16, 3, 4, 1'b1, 1'b0, 1'b1));
    drain();
    chk("raw_gap2_stalls", {16'd0, stall_cnt - s0}, 32'd2);

    // rt unused under imm_sel without store; used once store is set.
    s0 = stall_cnt;
    push(mk(5, 1, 2, 1'b0, 1'b0, 1'b1));
    push(mk(6, 7, 5, 1'b1, 1'b0, 1'b1));
    drain();
    chk("rt_unused_stalls", {16'd0, stall_cnt - s0}, 32'd0);
    s0 = stall_cnt;
    push(mk(5, 1, 2, 1'b0, 1'b0, 1'b1));
    push(mk(6, 7, 5, 1'b1, 1'b1, 1'b0));
    drain();
    chk("rt_store_stalls", {16'd0, stall_cnt - s0}, 32'd4);

    // Counter saturation and wrap.
    force dut.stall_cnt_q = 16'hFFFE;
    force dut.issue_cnt_q = 16'hFFFF;
    #1;
    release dut.stall_cnt_q;
    release dut.issue_cnt_q;
    m_stall = 16'hFFFE;
    m_issue = 16'hFFFF;
    push(mk(3, 1, 2, 1'b0, 1'b0, 1'b1));
    push(mk(7, 3, 9, 1'b1, 1'b0, 1'b0));
    drain();
    chk("stall_saturated", {16'd0, stall_cnt}, 32'h0000_FFFF);
    chk("issue_wrapped", {16'd0, issue_cnt}, 32'd1);

    // Asynchronous reset in the middle of a stall.
    push(mk(3, 1, 2, 1'b0, 1'b0, 1'b1));
    push(mk(7, 3, 9, 1'b1, 1'b0, 1'b1));
    cycle(NOP, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_out_inst", out_inst, NOP);
    chk("arst_stall", {16'd0, stall_cnt}, 32'd0);
    chk("arst_issue", {16'd0, issue_cnt}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    model_reset();
    @(posedge clk);
    edge_n++;
    #1;
    rst = 1'b0;
    cycle(NOP, 1'b0);
    chk("post_rst_no_issue", {31'd0, out_valid}, 32'd0);
    cycle(mk(8, 3, 3, 1'b0, 1'b0, 1'b1), 1'b1);
    cycle(NOP, 1'b0);
    chk("post_rst_first_issue", {31'd0, out_valid}, 32'd1);
    chk("post_rst_no_stall", {16'd0, stall_cnt}, 32'd0);

    // Random traffic on a small register set to provoke frequent hazards.
    for (int i = 0; i < 400; i++) begin
      w        = $urandom;
      w[31:27] = 5'($urandom_range(0, 3));
      w[26:22] = 5'($urandom_range(0, 3));
      w[21:17] = 5'($urandom_range(0, 3));
      cycle(w, ($urandom_range(0, 3) != 0));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
